// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel coordinates, active-video flag, syncs and line/frame start pulses.
// All outputs are decoded from the next position and registered together, so they never skew.
module vga_sync_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    output logic [9:0] px,
    output logic [9:0] py,
    output logic       video_active,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
            $error("vga_sync_gen: H_TOTAL/V_TOTAL do not fit the 10-bit position counters");
        end
    endgenerate

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] w_px_next;
    logic [9:0] w_py_next;
    logic       w_active_next;
    logic       w_hsync_on;
    logic       w_vsync_on;

    // Position the raster moves to on a strobe; py only advances on the horizontal wrap.
    always_comb begin
        w_px_next = px + 10'd1;
        w_py_next = py;
        if (px == H_LAST) begin
            w_px_next = '0;
            w_py_next = (py == V_LAST) ? '0 : py + 10'd1;
        end
    end

    assign w_active_next = (w_px_next < H_VIS) && (w_py_next < V_VIS);
    assign w_hsync_on    = (w_px_next >= HS_FIRST) && (w_px_next <= HS_LAST);
    assign w_vsync_on    = (w_py_next >= VS_FIRST) && (w_py_next <= VS_LAST);

    // NOTE: non-blocking assignments keep every register sampling pre-edge values, so
    // the decode of w_px_next/w_py_next and the position update land on the same edge.
    // NOTE: reset parks the raster on the last position with its decoded outputs, so the
    // first strobe after release lands on (0,0) with consistent flags and pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px           <= H_LAST;
            py           <= V_LAST;
            video_active <= 1'b0;
            hsync        <= ~SYNC_POL;
            vsync        <= ~SYNC_POL;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                px           <= w_px_next;
                py           <= w_py_next;
                video_active <= w_active_next;
                hsync        <= w_hsync_on ? SYNC_POL : ~SYNC_POL;
                vsync        <= w_vsync_on ? SYNC_POL : ~SYNC_POL;
                line_start   <= (w_px_next == '0);
                frame_start  <= (w_px_next == '0) && (w_py_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: default 640x480 build, a SYNC_POL=1 build,
// and a reduced-timing build that makes full-frame and mid-frame reset cases reachable.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_en = 1'b0;
    logic pix_en_s = 1'b0;

    always #5 clk = ~clk;

    logic [9:0] px, py;
    logic       video_active, hsync, vsync, line_start, frame_start;
    logic [9:0] p_px, p_py;
    logic       p_video_active, p_hsync, p_vsync, p_line_start, p_frame_start;
    logic [9:0] s_px, s_py;
    logic       s_video_active, s_hsync, s_vsync, s_line_start, s_frame_start;

    vga_sync_gen dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .px(px), .py(py), .video_active(video_active), .hsync(hsync), .vsync(vsync),
        .line_start(line_start), .frame_start(frame_start)
    );

    vga_sync_gen #(.SYNC_POL(1'b1)) dut_p (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .px(p_px), .py(p_py), .video_active(p_video_active), .hsync(p_hsync), .vsync(p_vsync),
        .line_start(p_line_start), .frame_start(p_frame_start)
    );

    // Small raster: 15 pixels x 12 lines, hsync at px 10..12, vsync on lines 7..8.
    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3)
    ) dut_s (
        .clk(clk), .rst(rst), .pix_en(pix_en_s),
        .px(s_px), .py(s_py), .video_active(s_video_active), .hsync(s_hsync), .vsync(s_vsync),
        .line_start(s_line_start), .frame_start(s_frame_start)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic tick(input logic r, input logic en, input logic en_s);
        @(negedge clk);
        rst = r;
        pix_en = en;
        pix_en_s = en_s;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [9:0] px;
        logic [9:0] py;
        logic       va, hs, vs, ls, fs;
    } vec_t;

    vec_t vecs[8];
    int   hold_err = 0;

    // Strobe every 4th clock; the three idle clocks must leave every output unchanged.
    task automatic strobe4();
        logic [23:0] snap;
        for (int k = 0; k < 3; k++) begin
            snap = {px, py, video_active, hsync, vsync, 1'b0};
            tick(1'b0, 1'b0, 1'b0);
            if ({px, py, video_active, hsync, vsync, line_start} !== snap || frame_start !== 1'b0)
                hold_err++;
        end
        tick(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int n;
        int va_cnt, hs_cnt, hs_first, hs_last, hsp_cnt, hsp_first, ls_cnt;
        int s_va, s_hs, s_vs, s_ls, s_fs, s_vs_first_x, s_vs_first_y;
        logic s_ls_at1;

        vecs[0] = '{1'b1, 1'b0, 10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 10'd1,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 10'd2,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 10'd2,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 8; i++) begin
            tick(vecs[i].rst, vecs[i].en, 1'b0);
            check($sformatf("vec%0d", i),
                  {px, py, video_active, hsync, vsync, line_start, frame_start},
                  {vecs[i].px, vecs[i].py, vecs[i].va, vecs[i].hs, vecs[i].vs, vecs[i].ls, vecs[i].fs});
            check($sformatf("vec%0d_pol1_sync", i), {p_hsync, p_vsync}, {~vecs[i].hs, ~vecs[i].vs});
        end

        // Finish line 0 from px=2: 798 strobes reach the wrap to (0,1).
        n = 0;
        do begin
            strobe4();
            n++;
        end while (px != 10'd0 && n < 1000);
        check("wrap_strobes", n, 798);
        check("wrap_to_line1", {px, py, line_start, frame_start}, {10'd0, 10'd1, 1'b1, 1'b0});

        // Full line 1 -> lands on (0,2).
        va_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
        hsp_cnt = 0; hsp_first = -1; ls_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            strobe4();
            if (video_active) va_cnt++;
            if (!hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(px);
                hs_last = int'(px);
            end
            if (p_hsync) begin
                hsp_cnt++;
                if (hsp_first < 0) hsp_first = int'(p_px);
            end
            if (line_start) ls_cnt++;
        end
        check("line_active_cnt", va_cnt, 640);
        check("line_hsync_cnt", hs_cnt, 96);
        check("line_hsync_first", hs_first, 656);
        check("line_hsync_last", hs_last, 751);
        check("line_pol1_hsync_cnt", hsp_cnt, 96);
        check("line_pol1_hsync_first", hsp_first, 656);
        check("line_start_cnt", ls_cnt, 1);
        check("line_end_pos", {px, py}, {10'd0, 10'd2});
        check("hold_between_strobes", hold_err, 0);

        // Small raster, continuous enable: first strobe, then one whole frame of 180 strobes.
        tick(1'b0, 1'b0, 1'b1);
        check("s_first", {s_px, s_py, s_video_active, s_line_start, s_frame_start},
              {10'd0, 10'd0, 1'b1, 1'b1, 1'b1});
        s_va = 0; s_hs = 0; s_vs = 0; s_ls = 0; s_fs = 0;
        s_vs_first_x = -1; s_vs_first_y = -1; s_ls_at1 = 1'bx;
        for (int i = 0; i < 180; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (i == 0) s_ls_at1 = s_line_start;
            if (s_video_active) s_va++;
            if (!s_hsync) s_hs++;
            if (!s_vsync) begin
                s_vs++;
                if (s_vs_first_x < 0) begin
                    s_vs_first_x = int'(s_px);
                    s_vs_first_y = int'(s_py);
                end
            end
            if (s_line_start) s_ls++;
            if (s_frame_start) s_fs++;
        end
        check("s_ls_low_at_px1", s_ls_at1, 1'b0);
        check("s_active_cnt", s_va, 48);
        check("s_hsync_cnt", s_hs, 36);
        check("s_vsync_cnt", s_vs, 30);
        check("s_vsync_first", {s_vs_first_x, s_vs_first_y}, {32'd0, 32'd7});
        check("s_line_start_cnt", s_ls, 12);
        check("s_frame_start_cnt", s_fs, 1);
        check("s_frame_wrap", {s_px, s_py, s_frame_start}, {10'd0, 10'd0, 1'b1});

        // Advance to (11,7), inside both sync pulses, then reset between clock edges.
        for (int i = 0; i < 116; i++) tick(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        pix_en_s = 1'b0;
        #2;
        check("s_pre_reset", {s_px, s_py, s_hsync, s_vsync}, {10'd11, 10'd7, 1'b0, 1'b0});
        rst = 1'b1;
        #1;
        check("s_async_reset", {s_px, s_py, s_video_active, s_hsync, s_vsync, s_line_start, s_frame_start},
              {10'd14, 10'd11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        check("async_reset", {px, py, video_active, hsync, vsync, line_start, frame_start},
              {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        check("pol1_async_reset_sync", {p_hsync, p_vsync}, 2'b00);
        tick(1'b1, 1'b1, 1'b1);
        check("reset_held", {s_px, s_py, px, py}, {10'd14, 10'd11, 10'd799, 10'd524});
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        check("post_reset_first", {px, py, video_active, line_start, frame_start},
              {10'd0, 10'd0, 1'b1, 1'b1, 1'b1});
        check("s_post_reset_first", {s_px, s_py, s_video_active, s_line_start, s_frame_start},
              {10'd0, 10'd0, 1'b1, 1'b1, 1'b1});
        tick(1'b0, 1'b1, 1'b1);
        check("continuous_px1", {px, line_start, frame_start}, {10'd1, 1'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- VGA/HDMI raster timing generator for the 640x480@60 video path.
- Produces the pixel coordinates px/py, the video_active flag, and the sync pulses consumed by the downstream pixel renderers (crosshair, box overlay) and the output encoder.
- Advances one pixel per pix_en strobe. pix_en comes from the 25 MHz pixel-clock divider on the system clock.
- All outputs are registered and mutually aligned: zero skew between coordinates, sync and active flag.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active-low, 1 = active-high)

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-high reset
- pix_en  input  1  pixel strobe; raster advances one position on each clk edge where pix_en=1
- px  output  10  current horizontal position, 0..H_TOTAL-1
- py  output  10  current vertical position, 0..V_TOTAL-1
- video_active  output  1  high when px<H_ACTIVE and py<V_ACTIVE
- hsync  output  1  horizontal sync, level per SYNC_POL
- vsync  output  1  vertical sync, level per SYNC_POL
- line_start  output  1  one-clk pulse when the raster enters px=0
- frame_start  output  1  one-clk pulse when the raster enters (0,0)

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Elaboration must fail if H_TOTAL>1024 or V_TOTAL>1024.
- Counters: px/py are the position registers themselves, 10 bits, unsigned, no other width conversion.
- On a clk edge with pix_en=1:
  - if px==H_TOTAL-1: px<=0, and py advances (py==V_TOTAL-1 -> py<=0, else py+1);
  - else px<=px+1 and py holds.
- On a clk edge with pix_en=0: px, py, video_active, hsync and vsync hold their values.
- Decode is from the next position, registered on the same edge, so all outputs describe the same pixel in the same cycle. Latency from pix_en to updated outputs is 1 clk.
- hsync is asserted (SYNC_POL level) iff H_ACTIVE+H_FP <= px <= H_ACTIVE+H_FP+H_SYNC-1 (656..751). Otherwise it is at ~SYNC_POL.
- vsync is asserted iff V_ACTIVE+V_FP <= py <= V_ACTIVE+V_FP+V_SYNC-1 (490..491). This depends on py only, so it changes on the edge where px wraps to 0.
- line_start is 1 for exactly one clk after an edge where pix_en=1 and the new px==0. It is 0 on every other edge, including the following edge whether or not pix_en is high.
- frame_start follows the same rule with the condition new px==0 and new py==0. It always coincides with a line_start pulse.
- Reset (async assert, values held while rst=1):
  - px=H_TOTAL-1 (799), py=V_TOTAL-1 (524);
  - video_active=0, hsync=~SYNC_POL, vsync=~SYNC_POL;
  - line_start=0, frame_start=0.
  - This is the decoded state of position (799,524), so the outputs are self-consistent.
- First pix_en after reset release moves the raster to (0,0) with video_active=1, line_start=1 and frame_start=1.
- Reset asserted mid-frame forces the reset values within the same cycle, independent of clk. No partial pulse survives.
- Reset release is synchronised externally; the block needs no internal synchroniser.
- pix_en held high every clk (strobe period 1) is legal: the raster then advances every clk.

Test Plan:
- Reset and first pixel: assert rst with clk running -> px=799, py=524, video_active=0, hsync=vsync=1 (SYNC_POL=0). Release rst, apply one pix_en -> px=0, py=0, video_active=1, line_start=1, frame_start=1 for one clk only.
- Horizontal timing: pix_en every 4th clk for one line -> video_active high for exactly 640 strobes (px 0..639). hsync low for exactly 96 strobes starting at px=656. Between strobes all outputs hold. Wrap 799->0 increments py by 1 and pulses line_start once.
- Vertical timing and frame wrap: run 525 lines -> vsync low for exactly lines 490 and 491 (1600 strobes total). video_active=0 for py>=480. At (799,524)->(0,0), frame_start pulses once; exactly one frame_start per 420000 strobes.
- Pulse width with continuous enable: pix_en=1 every clk across a line boundary -> line_start high for exactly one clk at px=0 and low at px=1.
- Async reset mid-frame: assert rst at px=700, py=490 (hsync and vsync both asserted), away from a clk edge -> outputs return to reset values before the next clk edge. After release and one pix_en, the raster is at (0,0) with frame_start=1.
- SYNC_POL=1 build: repeat the horizontal test -> hsync high exactly at px 656..751 and low during reset.
